// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM4x8 macro, with a one-word prefetch output register.
// Optional occupancy output `level` is built when RAM_FIFO_CTRL_LEVEL_EN is defined.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic              rd_pend;
  logic              rd_issue;
  logic              wr_en;

  // RAM port arbitration: a read issue wins over a write, a capture cycle blocks both
  always_comb begin
    rd_issue = !rd_pend && (count != '0) && (!out_valid || out_ready);
    in_ready = !rst && !rd_pend && !rd_issue && (count != FULL_CNT);
    wr_en    = in_valid && in_ready;
    ram_we   = wr_en;
    ram_d    = in_data;
    if (rd_pend) begin
      ram_addr = rptr - PTR_ONE;
    end else if (rd_issue) begin
      ram_addr = rptr;
    end else begin
      ram_addr = wptr;
    end
  end

  // Pointers, occupancy, read pipeline flag and the prefetch output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (rd_issue) begin
        rptr  <= rptr + PTR_ONE;
        count <= count - CNT_ONE;
      end else if (wr_en) begin
        wptr  <= wptr + PTR_ONE;
        count <= count + CNT_ONE;
      end
      rd_pend <= rd_issue;
      // A capture only happens while out_valid is low, so it never collides with a handshake
      if (rd_pend) begin
        out_data  <= ram_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RAM_FIFO_CTRL_LEVEL_EN
  localparam logic [ADDR_W:0] LVL_MAX = (ADDR_W+1)'(DEPTH + 1);
  logic [ADDR_W+1:0] level_sum;

  // Words held anywhere in the controller: RAM, in-flight read, output register
  always_comb begin
    level_sum = {1'b0, count} + (ADDR_W+2)'(rd_pend) + (ADDR_W+2)'(out_valid);
    if (rst) begin
      level = '0;
    end else if (level_sum > {1'b0, LVL_MAX}) begin
      level = LVL_MAX;
    end else begin
      level = level_sum[ADDR_W:0];
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural RAM and a queue-based reference model.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_d;
  logic [7:0] ram_q;
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  logic [2:0] level;
`endif

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clk = ~clk;

  // RAM4x8 behaviour: synchronous write, registered read data
  logic [7:0] mem [4];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  int total = 0;
  int bad = 0;

  // Reference model: words in RAM as a queue, plus in-flight read and output register
  logic [7:0] m_ram [$];
  int         m_wptr, m_rptr;
  bit         m_pend, m_ov;
  logic [7:0] m_pend_word, m_od;
  logic [7:0] popped [$];
  logic [7:0] accepted [$];
  logic       obs_we, obs_inrdy;
  logic [1:0] obs_addr;

  task automatic model_reset();
    m_ram.delete();
    m_wptr = 0; m_rptr = 0;
    m_pend = 1'b0; m_ov = 1'b0;
    m_pend_word = 8'h00; m_od = 8'h00;
  endtask

  task automatic clock_cycle(input logic iv, input logic [7:0] id, input logic ordy);
    logic e_issue, e_inrdy, e_we;
    logic [1:0] e_addr;
    int e_lvl;
    in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
    e_issue = !m_pend && (m_ram.size() != 0) && (!m_ov || ordy);
    e_inrdy = !m_pend && !e_issue && (m_ram.size() != 4);
    e_we    = iv && e_inrdy;
    if (m_pend) e_addr = 2'((m_rptr + 3) % 4);
    else if (e_issue) e_addr = 2'(m_rptr);
    else e_addr = 2'(m_wptr);
    total++; if (in_ready !== e_inrdy) begin bad++; $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, e_inrdy); end
    total++; if (ram_we !== e_we) begin bad++; $display("FAIL ram_we t=%0t got=%b exp=%b", $time, ram_we, e_we); end
    total++; if (ram_addr !== e_addr) begin bad++; $display("FAIL ram_addr t=%0t got=%0d exp=%0d", $time, ram_addr, e_addr); end
    total++; if (ram_d !== id) begin bad++; $display("FAIL ram_d t=%0t got=%h exp=%h", $time, ram_d, id); end
    total++; if (out_valid !== m_ov) begin bad++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, m_ov); end
    total++; if (out_data !== m_od) begin bad++; $display("FAIL out_data t=%0t got=%h exp=%h", $time, out_data, m_od); end
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    e_lvl = m_ram.size() + int'(m_pend) + int'(m_ov);
    if (e_lvl > 5) e_lvl = 5;
    total++; if (level !== 3'(e_lvl)) begin bad++; $display("FAIL level t=%0t got=%0d exp=%0d", $time, level, e_lvl); end
`else
    e_lvl = 0;
`endif
    obs_we = ram_we; obs_inrdy = in_ready; obs_addr = ram_addr;
    if (out_valid && ordy) popped.push_back(out_data);
    if (e_we) accepted.push_back(id);
    if (m_pend) begin
      m_od = m_pend_word; m_ov = 1'b1; m_pend = 1'b0;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (e_issue) begin
      m_pend_word = m_ram.pop_front(); m_rptr = (m_rptr + 1) % 4; m_pend = 1'b1;
    end
    if (e_we) begin
      m_ram.push_back(id); m_wptr = (m_wptr + 1) % 4;
    end
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [7:0] d, input logic ordy, output logic [1:0] addr, output bit ok);
    ok = 1'b0; addr = 2'd0;
    for (int i = 0; i < 20; i++) begin
      clock_cycle(1'b1, d, ordy);
      if (obs_we) begin addr = obs_addr; ok = 1'b1; return; end
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1; in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #2;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", ram_we); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_od got=%h exp=00", out_data); end
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    clock_cycle(1'b0, 8'h00, 1'b0);
    total++; if (obs_inrdy !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", obs_inrdy); end
    total++; if (obs_we !== 1'b0 || obs_addr !== 2'd0) begin bad++; $display("FAIL idle_ram got=%b/%0d exp=0/0", obs_we, obs_addr); end
  endtask

  task automatic test_single();
    popped.delete();
    clock_cycle(1'b1, 8'hA5, 1'b0);
    total++; if (obs_we !== 1'b1 || obs_addr !== 2'd0) begin bad++; $display("FAIL single_write got=%b/%0d exp=1/0", obs_we, obs_addr); end
    clock_cycle(1'b0, 8'h00, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", out_valid); end
    clock_cycle(1'b0, 8'h00, 1'b0);
    total++; if (obs_inrdy !== 1'b0) begin bad++; $display("FAIL single_capture_rdy got=%b exp=0", obs_inrdy); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin bad++; $display("FAIL single_out got=%b/%h exp=1/a5", out_valid, out_data); end
    clock_cycle(1'b0, 8'h00, 1'b1);
    total++; if (popped.size() != 1 || popped[0] !== 8'hA5) begin bad++; $display("FAIL single_pop got_n=%0d exp_n=1", popped.size()); end
  endtask

  task automatic test_fill();
    logic [1:0] a; bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_word(8'h10 + 8'(i), 1'b0, a, ok);
      total++; if (!ok || a !== 2'(i % 4)) begin bad++; $display("FAIL fill_push%0d got_ok=%0d addr=%0d exp_addr=%0d", i, ok, a, i % 4); end
    end
    for (int i = 0; i < 3; i++) begin
      clock_cycle(1'b1, 8'h15, 1'b0);
      total++; if (obs_inrdy !== 1'b0 || obs_we !== 1'b0) begin bad++; $display("FAIL full_block got=%b/%b exp=0/0", obs_inrdy, obs_we); end
    end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin bad++; $display("FAIL full_head got=%b/%h exp=1/10", out_valid, out_data); end
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    total++; if (level !== 3'd5) begin bad++; $display("FAIL full_level got=%0d exp=5", level); end
`endif
  endtask

  task automatic test_drain_wrap();
    logic [1:0] a; bit ok;
    popped.delete();
    for (int i = 0; i < 20; i++) clock_cycle(1'b0, 8'h00, 1'b1);
    total++; if (popped.size() != 5) begin bad++; $display("FAIL drain_count got=%0d exp=5", popped.size()); end
    for (int i = 0; i < popped.size() && i < 5; i++) begin
      total++; if (popped[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL drain_word%0d got=%h exp=%h", i, popped[i], 8'h10 + 8'(i)); end
    end
    popped.delete();
    push_word(8'h20, 1'b1, a, ok);
    total++; if (!ok || a !== 2'd1) begin bad++; $display("FAIL wrap_addr20 got=%0d exp=1", a); end
    push_word(8'h21, 1'b1, a, ok);
    total++; if (!ok || a !== 2'd2) begin bad++; $display("FAIL wrap_addr21 got=%0d exp=2", a); end
    for (int i = 0; i < 10; i++) clock_cycle(1'b0, 8'h00, 1'b1);
    total++; if (popped.size() != 2 || popped[0] !== 8'h20 || popped[1] !== 8'h21) begin bad++; $display("FAIL wrap_order got_n=%0d exp_n=2", popped.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d = 8'h00;
    popped.delete(); accepted.delete();
    for (int i = 0; i < 20; i++) begin
      clock_cycle(1'b1, d, 1'b1);
      if (obs_we) d++;
    end
    for (int i = 0; i < 20; i++) clock_cycle(1'b0, 8'h00, 1'b1);
    total++; if (accepted.size() < 5 || popped.size() != accepted.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", popped.size(), accepted.size()); end
    for (int i = 0; i < popped.size(); i++) begin
      total++; if (popped[i] !== 8'(i)) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, popped[i], 8'(i)); end
    end
  endtask

  task automatic test_random();
    popped.delete(); accepted.delete();
    for (int i = 0; i < 300; i++)
      clock_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 30; i++) clock_cycle(1'b0, 8'h00, 1'b1);
    total++; if (popped.size() != accepted.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", popped.size(), accepted.size()); end
    for (int i = 0; i < popped.size() && i < accepted.size(); i++) begin
      total++; if (popped[i] !== accepted[i]) begin bad++; $display("FAIL rand_word%0d got=%h exp=%h", i, popped[i], accepted[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    clock_cycle(1'b1, 8'h77, 1'b0);
    clock_cycle(1'b0, 8'h00, 1'b0);
    in_valid = 1'b1; in_data = 8'h99;
    #2 rst = 1'b1;
    #1;
    total++; if (ram_we !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_async got=%b/%b exp=0/0", ram_we, out_valid); end
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    total++; if (level !== 3'd0) begin bad++; $display("FAIL midrst_level got=%0d exp=0", level); end
`endif
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_capture got=%b exp=0", out_valid); end
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    clock_cycle(1'b1, 8'h3C, 1'b0);
    total++; if (obs_we !== 1'b1 || obs_addr !== 2'd0) begin bad++; $display("FAIL midrst_push got=%b/%0d exp=1/0", obs_we, obs_addr); end
    clock_cycle(1'b0, 8'h00, 1'b0);
    clock_cycle(1'b0, 8'h00, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin bad++; $display("FAIL midrst_out got=%b/%h exp=1/3c", out_valid, out_data); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
